// File: rtl/rv_ctl.sv
// Multicycle control FSM for the RISC-V datapath: decodes the latched IR each
// cycle, sequences the instruction and emits every datapath strobe.
module rv_ctl #(
    parameter int DPWIDTH = 32,
    parameter int CNTW    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DPWIDTH-1:0] instr,
    input  logic               zero,
    output logic               pcsourse,
    output logic               pcwrite,
    output logic               pccen,
    output logic               irwrite,
    output logic [1:0]         wbsel,
    output logic               regwen,
    output logic [1:0]         immsel,
    output logic               asel,
    output logic               bsel,
    output logic [3:0]         alusel,
    output logic               mdrwrite,
    output logic               inv_en,
    output logic               dmem_wen,
    output logic               halted,
    output logic               retire,
    output logic [CNTW-1:0]    retired_cnt
);

    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_EXEC_R   = 4'd2;
    localparam logic [3:0] ST_EXEC_I   = 4'd3;
    localparam logic [3:0] ST_ALU_WB   = 4'd4;
    localparam logic [3:0] ST_MEM_ADDR = 4'd5;
    localparam logic [3:0] ST_MEM_RD   = 4'd6;
    localparam logic [3:0] ST_MEM_WB   = 4'd7;
    localparam logic [3:0] ST_MEM_WR   = 4'd8;
    localparam logic [3:0] ST_BRANCH   = 4'd9;
    localparam logic [3:0] ST_JAL      = 4'd10;
    localparam logic [3:0] ST_HALT     = 4'd11;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_SW2    = 7'b0001011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [1:0] IMM_I = 2'd0;
    localparam logic [1:0] IMM_S = 2'd1;
    localparam logic [1:0] IMM_B = 2'd2;
    localparam logic [1:0] IMM_J = 2'd3;

    logic [3:0]      r_state;
    logic [3:0]      w_next;
    logic [CNTW-1:0] r_retiredCnt;
    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic            w_f7b;
    logic            w_unusedInstr;

    assign w_opcode      = instr[6:0];
    assign w_funct3      = instr[14:12];
    assign w_f7b         = instr[30];
    assign w_unusedInstr = ^{instr[DPWIDTH-1:31], instr[29:15], instr[11:7]};

    // f7b selects SUB only for register-register ops; SRA/SRL honour it for both
    function automatic logic [3:0] aluDecode(input logic [2:0] f3, input logic f7b,
                                             input logic isR);
        logic [3:0] sel;
        case (f3)
            3'b000:  sel = (isR && f7b) ? ALU_SUB : ALU_ADD;
            3'b001:  sel = ALU_SLL;
            3'b010:  sel = ALU_SLT;
            3'b011:  sel = ALU_SLTU;
            3'b100:  sel = ALU_XOR;
            3'b101:  sel = f7b ? ALU_SRA : ALU_SRL;
            3'b110:  sel = ALU_OR;
            default: sel = ALU_AND;
        endcase
        return sel;
    endfunction

    always_comb begin
        w_next   = r_state;
        pcsourse = 1'b0;
        pcwrite  = 1'b0;
        pccen    = 1'b0;
        irwrite  = 1'b0;
        wbsel    = 2'd0;
        regwen   = 1'b0;
        immsel   = IMM_I;
        asel     = 1'b0;
        bsel     = 1'b0;
        alusel   = ALU_ADD;
        mdrwrite = 1'b0;
        inv_en   = 1'b0;
        dmem_wen = 1'b0;
        halted   = 1'b0;
        retire   = 1'b0;
        case (r_state)
            ST_FETCH: begin
                irwrite = 1'b1;
                pccen   = 1'b1;
                pcwrite = 1'b1;
                w_next  = ST_DECODE;
            end
            ST_DECODE: begin
                // Speculatively form PC+imm so BRANCH/JAL find the target in ALUOUT
                asel   = 1'b1;
                bsel   = 1'b1;
                alusel = ALU_ADD;
                immsel = (w_opcode == OP_JAL) ? IMM_J : IMM_B;
                case (w_opcode)
                    OP_R:      w_next = ST_EXEC_R;
                    OP_I:      w_next = ST_EXEC_I;
                    OP_LOAD,
                    OP_STORE,
                    OP_SW2:    w_next = (w_funct3 == 3'b010) ? ST_MEM_ADDR : ST_HALT;
                    OP_BRANCH: w_next = (w_funct3[2:1] == 2'b00) ? ST_BRANCH : ST_HALT;
                    OP_JAL:    w_next = ST_JAL;
                    default:   w_next = ST_HALT;
                endcase
            end
            ST_EXEC_R: begin
                alusel = aluDecode(w_funct3, w_f7b, 1'b1);
                w_next = ST_ALU_WB;
            end
            ST_EXEC_I: begin
                bsel   = 1'b1;
                immsel = IMM_I;
                alusel = aluDecode(w_funct3, w_f7b, 1'b0);
                w_next = ST_ALU_WB;
            end
            ST_ALU_WB: begin
                wbsel  = 2'd1;
                regwen = 1'b1;
                retire = 1'b1;
                w_next = ST_FETCH;
            end
            ST_MEM_ADDR: begin
                bsel   = 1'b1;
                alusel = ALU_ADD;
                immsel = (w_opcode == OP_LOAD) ? IMM_I : IMM_S;
                w_next = (w_opcode == OP_LOAD) ? ST_MEM_RD : ST_MEM_WR;
            end
            ST_MEM_RD: begin
                mdrwrite = 1'b1;
                w_next   = ST_MEM_WB;
            end
            ST_MEM_WB: begin
                wbsel  = 2'd0;
                regwen = 1'b1;
                retire = 1'b1;
                w_next = ST_FETCH;
            end
            ST_MEM_WR: begin
                dmem_wen = 1'b1;
                inv_en   = (w_opcode == OP_SW2);
                retire   = 1'b1;
                w_next   = ST_FETCH;
            end
            ST_BRANCH: begin
                alusel   = ALU_SUB;
                pcsourse = 1'b1;
                pcwrite  = (w_funct3 == 3'b000) ? zero : ~zero;
                retire   = 1'b1;
                w_next   = ST_FETCH;
            end
            ST_JAL: begin
                wbsel    = 2'd2;
                regwen   = 1'b1;
                pcwrite  = 1'b1;
                pcsourse = 1'b1;
                retire   = 1'b1;
                w_next   = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
                w_next = ST_HALT;
            end
            default: w_next = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_FETCH;
            r_retiredCnt <= '0;
        end else begin
            r_state <= w_next;
            if (retire) begin
                r_retiredCnt <= r_retiredCnt + 1'b1;
            end
        end
    end

    assign retired_cnt = r_retiredCnt;

endmodule

// File: tb/tb_rv_ctl.sv
// Bench for rv_ctl: an instruction-level model predicts every cycle's control
// vector; a compare process checks the DUT each negedge plus literal pin points.
module tb_rv_ctl;

    localparam int DPWIDTH = 32;
    localparam int CNTW    = 32;

    typedef struct packed {
        logic       pcsourse;
        logic       pcwrite;
        logic       pccen;
        logic       irwrite;
        logic [1:0] wbsel;
        logic       regwen;
        logic [1:0] immsel;
        logic       asel;
        logic       bsel;
        logic [3:0] alusel;
        logic       mdrwrite;
        logic       invEn;
        logic       dmemWen;
        logic       halted;
        logic       retire;
    } ctl_t;

    logic               clk = 1'b0;
    logic               rst;
    logic [DPWIDTH-1:0] instr;
    logic               zero;
    logic               pcsourse, pcwrite, pccen, irwrite, regwen, asel, bsel;
    logic               mdrwrite, inv_en, dmem_wen, halted, retire;
    logic [1:0]         wbsel, immsel;
    logic [3:0]         alusel;
    logic [CNTW-1:0]    retired_cnt;

    ctl_t dutCtl;
    assign dutCtl = {pcsourse, pcwrite, pccen, irwrite, wbsel, regwen, immsel, asel, bsel,
                     alusel, mdrwrite, inv_en, dmem_wen, halted, retire};

    rv_ctl #(.DPWIDTH(DPWIDTH), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero),
        .pcsourse(pcsourse), .pcwrite(pcwrite), .pccen(pccen), .irwrite(irwrite),
        .wbsel(wbsel), .regwen(regwen), .immsel(immsel), .asel(asel), .bsel(bsel),
        .alusel(alusel), .mdrwrite(mdrwrite), .inv_en(inv_en), .dmem_wen(dmem_wen),
        .halted(halted), .retire(retire), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    ctl_t expArr [0:255];
    int   wrIdx = 0;
    int   rdIdx = 0;
    ctl_t plan [$];
    int   planLen = 0;

    logic      pinStrobe = 1'b0;
    ctl_t      pinCtl;
    logic      pinUseCtl, pinUseCnt, pinUseLen;
    int        pinCnt, pinLen;

    // ALU code from the mnemonic table; f7b adds one for SUB (R only) and SRA
    function automatic logic [3:0] aluFor(input logic [2:0] f3, input logic f7b, input logic isR);
        logic [3:0] base [0:7];
        logic       bump;
        base = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        bump = f7b && ((f3 == 3'd0 && isR) || f3 == 3'd5);
        return base[f3] + (bump ? 4'd1 : 4'd0);
    endfunction

    task automatic buildPlan(input logic [31:0] ins, input logic z, input int haltCycles);
        logic [6:0] op;
        logic [2:0] f3;
        ctl_t       c;
        op = ins[6:0];
        f3 = ins[14:12];
        plan.delete();
        c = '0; c.pcwrite = 1; c.pccen = 1; c.irwrite = 1; plan.push_back(c);
        c = '0; c.asel = 1; c.bsel = 1; c.immsel = (op == 7'b1101111) ? 2'd3 : 2'd2;
        plan.push_back(c);
        if (op == 7'b0110011 || op == 7'b0010011) begin
            c = '0; c.bsel = (op == 7'b0010011);
            c.alusel = aluFor(f3, ins[30], op == 7'b0110011);
            plan.push_back(c);
            c = '0; c.wbsel = 2'd1; c.regwen = 1; c.retire = 1; plan.push_back(c);
        end else if (f3 == 3'b010 &&
                     (op == 7'b0000011 || op == 7'b0100011 || op == 7'b0001011)) begin
            c = '0; c.bsel = 1; c.immsel = (op == 7'b0000011) ? 2'd0 : 2'd1; plan.push_back(c);
            if (op == 7'b0000011) begin
                c = '0; c.mdrwrite = 1; plan.push_back(c);
                c = '0; c.regwen = 1; c.retire = 1; plan.push_back(c);
            end else begin
                c = '0; c.dmemWen = 1; c.invEn = (op == 7'b0001011); c.retire = 1;
                plan.push_back(c);
            end
        end else if (op == 7'b1100011 && (f3 == 3'b000 || f3 == 3'b001)) begin
            c = '0; c.alusel = 4'd1; c.pcsourse = 1; c.retire = 1;
            c.pcwrite = (f3 == 3'b000) ? z : !z;
            plan.push_back(c);
        end else if (op == 7'b1101111) begin
            c = '0; c.wbsel = 2'd2; c.regwen = 1; c.pcwrite = 1; c.pcsourse = 1; c.retire = 1;
            plan.push_back(c);
        end else begin
            for (int i = 0; i < haltCycles; i++) begin
                c = '0; c.halted = 1; plan.push_back(c);
            end
        end
        planLen = plan.size();
    endtask

    // Must be called with the DUT sitting in FETCH, just after a rising edge
    task automatic applyStimulus(input logic [31:0] ins, input logic z, input int keep);
        instr = ins;
        zero  = z;
        buildPlan(ins, z, 20);
        for (int i = 0; i < planLen && i < keep; i++) begin
            expArr[wrIdx % 256] = plan[i];
            wrIdx++;
        end
        if (keep >= planLen) begin
            repeat (planLen) @(posedge clk);
            #1;
        end
    endtask

    task automatic pinCheck(input ctl_t c, input logic useCtl, input int cnt, input logic useCnt,
                            input int len, input logic useLen);
        pinCtl    = c;
        pinUseCtl = useCtl;
        pinCnt    = cnt;
        pinUseCnt = useCnt;
        pinLen    = len;
        pinUseLen = useLen;
        pinStrobe = 1'b1;
        #1;
        pinStrobe = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [CNTW-1:0] modelCnt = '0;

    initial begin : compareProc
        ctl_t e;
        forever begin
            @(negedge clk or posedge pinStrobe);
            if (pinStrobe) begin
                if (pinUseCtl) checkOutput("pinCtl", 32'(dutCtl), 32'(pinCtl));
                if (pinUseCnt) checkOutput("pinCnt", retired_cnt, pinCnt);
                if (pinUseLen) checkOutput("pinLatency", planLen, pinLen);
            end else if (rst) begin
                modelCnt = '0;
            end else if (rdIdx < wrIdx) begin
                e = expArr[rdIdx % 256];
                checkOutput($sformatf("ctl#%0d", rdIdx), 32'(dutCtl), 32'(e));
                checkOutput($sformatf("cnt#%0d", rdIdx), retired_cnt, modelCnt);
                checkOutput($sformatf("excl#%0d", rdIdx),
                            32'($countones({regwen, dmem_wen, mdrwrite, irwrite}) <= 1), 32'd1);
                if (e.retire) modelCnt = modelCnt + 1'b1;
                rdIdx++;
            end
        end
    end

    logic [31:0] vecIns  [0:13] = '{32'h002081B3, 32'h0080A283, 32'h00208063, 32'h00208063,
                                    32'h00209063, 32'h00209063, 32'h010000EF, 32'h0020A00B,
                                    32'h0020A023, 32'h403100B3, 32'h4030D093, 32'h40000093,
                                    32'h003130B3, 32'h003170B3};
    logic        vecZero [0:13] = '{0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int          vecLat  [0:13] = '{4, 5, 3, 3, 3, 3, 3, 4, 4, 4, 4, 4, 4, 4};

    initial begin : stimProc
        ctl_t fetchLit;
        ctl_t haltLit;
        fetchLit = '0; fetchLit.pcwrite = 1; fetchLit.pccen = 1; fetchLit.irwrite = 1;
        haltLit  = '0; haltLit.halted = 1;
        rst   = 1'b1;
        instr = '0;
        zero  = 1'b0;
        pinCtl = '0; pinUseCtl = 0; pinUseCnt = 0; pinUseLen = 0; pinCnt = 0; pinLen = 0;

        repeat (2) @(negedge clk);
        #2;
        pinCheck(fetchLit, 1, 0, 1, 0, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecIns[i], vecZero[i], 99);
            pinCheck('0, 0, i + 1, 1, vecLat[i], 1);
        end

        applyStimulus(32'hFFFFFFFF, 1'b0, 99);
        pinCheck(haltLit, 1, 14, 1, 22, 1);

        rst = 1'b1;
        #1;
        pinCheck(fetchLit, 1, 0, 1, 0, 0);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        applyStimulus(32'h002081B3, 1'b0, 99);
        pinCheck('0, 0, 1, 1, 0, 0);

        // Abandon an add while in EXEC_R; the counter must clear straight away
        applyStimulus(32'h002081B3, 1'b0, 3);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        pinCheck(fetchLit, 1, 0, 1, 0, 0);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        applyStimulus(32'h0020A023, 1'b0, 99);
        pinCheck('0, 0, 1, 1, 4, 1);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
